// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the digit-serial ALU:
//   - op code constants {a_invert, b_negate, sel[1:0]}
//   - FSM state encoding (IDLE, RUN, DONE)
//   - cnt_width(): slice counter width from WIDTH/SLICE
//   - is_legal_op(): true for the six supported op codes
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // A single-slice configuration still gets a one-bit counter, so the
   // counter declaration never collapses to a zero-width vector.
   function automatic int cnt_width(input int width, input int slice);
      int n;
      n = width / slice;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic is_legal_op(input logic [3:0] code);
      return (code == ALU_AND) || (code == ALU_OR)  || (code == ALU_ADD) ||
             (code == ALU_SUB) || (code == ALU_SLT) || (code == ALU_NOR);
   endfunction

endpackage

// File: rtl/alu_slice.sv
// -----------------------------------------------------------------------------
// alu_slice
// Combinational SLICE-bit ripple of one-bit ALU cells. Each cell conditionally
// inverts a and b, then selects AND / OR / SUM / less by sel.
// Ports:
//   a, b          : slice operands
//   carry_in      : carry into bit 0 of this slice
//   a_invert      : invert a before use
//   b_negate      : invert b before use (caller supplies the +1 as carry)
//   sel           : 00 AND, 01 OR, 10 SUM, 11 less
//   less          : value placed on bit 0 when sel = 11 (upper bits get 0)
//   result        : slice result
//   carry_out     : carry out of the slice MSB
//   msb_carry_in  : carry into the slice MSB (for overflow detection)
//   msb_sum       : adder sum bit of the slice MSB (for set-less-than)
// -----------------------------------------------------------------------------
module alu_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             carry_in,
   input  logic             a_invert,
   input  logic             b_negate,
   input  logic [1:0]       sel,
   input  logic             less,
   output logic [SLICE-1:0] result,
   output logic             carry_out,
   output logic             msb_carry_in,
   output logic             msb_sum
);

   // Ripple the carry through the cells from bit 0 upward. The adder is
   // evaluated for every sel value so the carry chain is always meaningful.
   always_comb begin
      logic c;
      logic ai;
      logic bi;
      logic s;
      c            = carry_in;
      result       = '0;
      msb_carry_in = 1'b0;
      msb_sum      = 1'b0;
      for (int i = 0; i < SLICE; i++) begin
         ai = a[i] ^ a_invert;
         bi = b[i] ^ b_negate;
         s  = ai ^ bi ^ c;
         case (sel)
            2'b00:   result[i] = ai & bi;
            2'b01:   result[i] = ai | bi;
            2'b10:   result[i] = s;
            default: result[i] = (i == 0) ? less : 1'b0;
         endcase
         if (i == SLICE - 1) begin
            msb_carry_in = c;
            msb_sum      = s;
         end
         c = (ai & bi) | (ai & c) | (bi & c);
      end
      carry_out = c;
   end

endmodule

// File: rtl/multi_cycle_alu.sv
// -----------------------------------------------------------------------------
// multi_cycle_alu
// WIDTH-bit digit-serial ALU processing SLICE bits per clock, LSB slice first.
// Start is accepted only in IDLE; operands and op are latched, RUN walks the
// slices, DONE pulses done for one cycle with valid result and flags.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   start_in   : request, sampled only in IDLE
//   a_in, b_in : operands, latched on accepted start
//   op         : {a_invert, b_negate, sel[1:0]}, latched on accepted start
//   busy       : high in RUN and DONE
//   done       : one-cycle pulse when result and flags are valid
//   result     : registered result
//   zero       : final result == 0
//   overflow   : signed overflow of the adder path
//   carry_out  : adder carry out of the MSB
//   ovf_trap   : sticky trap on ADD/SUB overflow
// Configuration macro:
//   ALU_OVF_TRAP_EN : when defined, ovf_trap logic is built; otherwise the
//                     port is tied to 0.
// -----------------------------------------------------------------------------
module multi_cycle_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [3:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             carry_out,
   output logic             ovf_trap
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = cnt_width(WIDTH, SLICE);
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("multi_cycle_alu: WIDTH must be a multiple of SLICE");
   end

   logic [1:0]                   state;
   logic [CW-1:0]                cnt;
   logic [NSLICE-1:0][SLICE-1:0] a_q;
   logic [NSLICE-1:0][SLICE-1:0] b_q;
   logic [NSLICE-1:0][SLICE-1:0] res_q;
   logic [NSLICE-1:0][SLICE-1:0] next_res;
   logic [3:0]                   op_q;
   logic                         carry_q;

   logic [SLICE-1:0] slice_res;
   logic             slice_cout;
   logic             slice_msb_cin;
   logic             slice_msb_sum;

   logic legal;
   logic is_slt;
   logic last;
   logic ovf_next;
   logic set_bit;

   assign legal    = is_legal_op(op_q);
   assign is_slt   = (op_q == ALU_SLT);
   assign last     = (cnt == LAST);
   assign ovf_next = slice_msb_cin ^ slice_cout;
   assign set_bit  = slice_msb_sum ^ ovf_next;

   assign busy   = (state != IDLE);
   assign result = res_q;

   // The less input is tied low: SLT's answer is only known after the MSB
   // slice, so bit 0 is patched in the final RUN cycle instead.
   alu_slice #(.SLICE(SLICE)) u_slice (
      .a            (a_q[cnt]),
      .b            (b_q[cnt]),
      .carry_in     (carry_q),
      .a_invert     (op_q[3]),
      .b_negate     (op_q[2]),
      .sel          (op_q[1:0]),
      .less         (1'b0),
      .result       (slice_res),
      .carry_out    (slice_cout),
      .msb_carry_in (slice_msb_cin),
      .msb_sum      (slice_msb_sum)
   );

   // Build the result as it will look after this RUN cycle: the current slice
   // is replaced, illegal ops write zeros, and on the last slice SLT
   // overwrites bit 0 with the signed less-than outcome.
   always_comb begin
      next_res      = res_q;
      next_res[cnt] = legal ? slice_res : '0;
      if (last && is_slt && legal) begin
         next_res[0][0] = set_bit;
      end
   end

   // Main FSM plus datapath registers. Result and flags are deliberately not
   // cleared on start; they change slice by slice and hold after DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         carry_q   <= 1'b0;
         res_q     <= '0;
         done      <= 1'b0;
         zero      <= 1'b0;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_in) begin
                  a_q     <= a_in;
                  b_q     <= b_in;
                  op_q    <= op;
                  cnt     <= '0;
                  carry_q <= op[2];
                  state   <= RUN;
               end
            end
            RUN: begin
               res_q   <= next_res;
               carry_q <= slice_cout;
               cnt     <= cnt + 1'b1;
               if (last) begin
                  overflow  <= legal ? ovf_next : 1'b0;
                  carry_out <= legal ? slice_cout : 1'b0;
                  zero      <= (next_res == '0);
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ALU_OVF_TRAP_EN
   // Sticky trap: raised together with done when an ADD or SUB overflows,
   // held until reset or the next accepted start.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_trap <= 1'b0;
      end else if (state == IDLE && start_in) begin
         ovf_trap <= 1'b0;
      end else if (state == RUN && last && ovf_next &&
                   (op_q == ALU_ADD || op_q == ALU_SUB)) begin
         ovf_trap <= 1'b1;
      end
   end
`else
   assign ovf_trap = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_alu.sv
// -----------------------------------------------------------------------------
// tb_multi_cycle_alu
// Self-checking bench for multi_cycle_alu (WIDTH=32, SLICE=8). Expected values
// come from a plain-arithmetic reference model. Honours ALU_OVF_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_multi_cycle_alu;

   localparam int WIDTH  = 32;
   localparam int SLICE  = 8;
   localparam int NSLICE = WIDTH / SLICE;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_in;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic [3:0]  op;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        carry_out;
   logic        ovf_trap;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] res;
      logic        zero;
      logic        ovf;
      logic        cout;
      logic        trap;
   } exp_t;

   multi_cycle_alu #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk       (clk),
      .reset     (reset),
      .start_in  (start_in),
      .a_in      (a_in),
      .b_in      (b_in),
      .op        (op),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .carry_out (carry_out),
      .ovf_trap  (ovf_trap)
   );

   always #5 clk = ~clk;

   // Reference model: the adder path is always a' + b' + b_negate, logic ops
   // are evaluated directly on the operands.
   function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] o);
      exp_t        e;
      logic [31:0] aa;
      logic [31:0] bb;
      logic [32:0] s;
      aa     = o[3] ? ~a : a;
      bb     = o[2] ? ~b : b;
      s      = {1'b0, aa} + {1'b0, bb} + 33'(o[2]);
      e.ovf  = (aa[31] == bb[31]) && (s[31] != aa[31]);
      e.cout = s[32];
      e.trap = 1'b0;
      case (o)
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b0010: e.res = a + b;
         4'b0110: e.res = a - b;
         4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1100: e.res = ~(a | b);
         default: begin
            e.res  = 32'd0;
            e.ovf  = 1'b0;
            e.cout = 1'b0;
         end
      endcase
      e.zero = (e.res == 32'd0);
`ifdef ALU_OVF_TRAP_EN
      e.trap = e.ovf && (o == 4'b0010 || o == 4'b0110);
`endif
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Issue one op, scramble the inputs after acceptance, wait for done and
   // compare everything against the model; then confirm done was a pulse.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] o, input string tag);
      exp_t e;
      int   lat;
      e        = refModel(a, b, o);
      a_in     = a;
      b_in     = b;
      op       = o;
      start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      a_in     = $urandom;
      b_in     = $urandom;
      op       = 4'($urandom);
      checkOutput({tag, ".busy_run"}, 32'(busy), 32'd1);
      lat = 1;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({tag, ".latency"}, 32'(lat), 32'(NSLICE + 1));
      checkOutput({tag, ".result"}, result, e.res);
      checkOutput({tag, ".zero"}, 32'(zero), 32'(e.zero));
      checkOutput({tag, ".overflow"}, 32'(overflow), 32'(e.ovf));
      checkOutput({tag, ".carry_out"}, 32'(carry_out), 32'(e.cout));
      checkOutput({tag, ".ovf_trap"}, 32'(ovf_trap), 32'(e.trap));
      @(negedge clk);
      checkOutput({tag, ".done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, ".busy_idle"}, 32'(busy), 32'd0);
      checkOutput({tag, ".hold"}, result, e.res);
   endtask

   initial begin
      logic [3:0]  legal_ops [6];
      logic [31:0] edge_vals [6];
      logic [31:0] ha [16];
      logic [31:0] hb [16];
      logic [3:0]  ho [16];
      int          exp_done_at [$];
      int          done_seen;
      int          k;
      exp_t        e;

      legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
      edge_vals = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                    32'h8000_0000, 32'h0000_0001, 32'h0000_00FF};

      reset    = 1'b1;
      start_in = 1'b0;
      a_in     = '0;
      b_in     = '0;
      op       = '0;
      repeat (3) @(negedge clk);
      checkOutput("rst.busy", 32'(busy), 32'd0);
      checkOutput("rst.done", 32'(done), 32'd0);
      checkOutput("rst.result", result, 32'd0);
      checkOutput("rst.flags", {28'd0, zero, overflow, carry_out, ovf_trap}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, "add_ovf");
      applyStimulus(32'h0000_0005, 32'h0000_0005, 4'b0110, "sub_zero");
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, "slt_neg");
      applyStimulus(32'h0000_0001, 32'hFFFF_FFFF, 4'b0111, "slt_pos");
      applyStimulus(32'h8000_0000, 32'h0000_0001, 4'b0111, "slt_ovf");
      applyStimulus(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, "and");
      applyStimulus(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0001, "or");
      applyStimulus(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1100, "nor");
      applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 4'b1111, "illegal");
      applyStimulus(32'h8000_0000, 32'h0000_0001, 4'b0110, "sub_ovf");

      // Reset two cycles into an ADD: no done, everything cleared.
      a_in     = 32'h1234_5678;
      b_in     = 32'h1111_1111;
      op       = 4'b0010;
      start_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort.busy", 32'(busy), 32'd0);
      checkOutput("abort.done", 32'(done), 32'd0);
      checkOutput("abort.result", result, 32'd0);
      checkOutput("abort.flags", {28'd0, zero, overflow, carry_out, ovf_trap}, 32'd0);
      done_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      checkOutput("abort.no_done", 32'(done_seen), 32'd0);
      applyStimulus(32'h0000_0010, 32'h0000_0020, 4'b0010, "after_abort");

      // start_in held for 10 cycles with fresh operands every cycle. Starts
      // are accepted only when idle, i.e. every NSLICE+2 cycles.
      for (int t = 0; t < 10; t += NSLICE + 2) exp_done_at.push_back(t);
      for (int i = 0; i < 16; i++) begin
         ha[i] = $urandom;
         hb[i] = $urandom;
         ho[i] = legal_ops[$urandom_range(0, 5)];
      end
      a_in      = ha[0];
      b_in      = hb[0];
      op        = ho[0];
      start_in  = 1'b1;
      done_seen = 0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (done) begin
            if (done_seen < exp_done_at.size()) begin
               k = exp_done_at[done_seen];
               e = refModel(ha[k], hb[k], ho[k]);
               checkOutput("hold.when", 32'(i), 32'(k + NSLICE + 1));
               checkOutput("hold.result", result, e.res);
            end
            done_seen++;
         end
         if (i < 10) begin
            a_in = ha[i];
            b_in = hb[i];
            op   = ho[i];
         end else begin
            start_in = 1'b0;
         end
      end
      checkOutput("hold.count", 32'(done_seen), 32'(exp_done_at.size()));

      // Random mix of legal and occasional illegal ops with edge operands.
      for (int n = 0; n < 40; n++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         logic [3:0]  ro;
         ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
         ro = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 5)];
         applyStimulus(ra, rb, ro, $sformatf("rand%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
